// File: rtl/axi4_stream_pkt_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
//   state_t        : generator FSM states
//   beats_per_pkt  : ceil(len / bytes)
//   last_keep      : TKEEP mask for the final beat of a packet (caller slices)
//   pattern_byte   : deterministic payload byte for packet p, beat b, lane i
package axi4_stream_pkt_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_DONE
   } state_t;

   function automatic int unsigned beats_per_pkt(input int unsigned len,
                                                 input int unsigned bytes);
      return (len + bytes - 1) / bytes;
   endfunction

   // A length that fills the last beat exactly keeps every lane.
   function automatic logic [63:0] last_keep(input int unsigned len,
                                             input int unsigned bytes);
      int unsigned rem;
      rem = len % bytes;
      if (rem == 0) return '1;
      return ~(~64'd0 << rem);
   endfunction

   function automatic logic [7:0] pattern_byte(input int unsigned p,
                                               input int unsigned b,
                                               input int unsigned i,
                                               input int unsigned bytes);
      return 8'(p + b * bytes + i);
   endfunction

endpackage

// File: rtl/axi4_stream_pkt_ctr.sv
// Beat / packet counter pair for the packet generator.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : clear both counters and latch beats-per-packet / packet count
//   en         : advance one beat (one handshake)
//   nb, npkt   : beats per packet and packets per run, latched on load
//   nb_q       : latched beats per packet
//   last_beat  : current beat is the final beat of its packet
//   last_pkt   : current packet is the final packet of the run
//   beat_nxt, pkt_nxt : indices of the beat that follows the current one
module axi4_stream_pkt_ctr
   import axi4_stream_pkt_gen_pkg::*;
#(
   parameter int NBW  = 17,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            en,
   input  logic [NBW-1:0]  nb,
   input  logic [CNTW-1:0] npkt,
   output logic [NBW-1:0]  nb_q,
   output logic            last_beat,
   output logic            last_pkt,
   output logic [NBW-1:0]  beat_nxt,
   output logic [CNTW-1:0] pkt_nxt
);

   logic [NBW-1:0]  beat;
   logic [CNTW-1:0] pkt;
   logic [CNTW-1:0] npkt_q;

   assign last_beat = (beat == nb_q - NBW'(1));
   assign last_pkt  = (pkt == npkt_q - CNTW'(1));
   assign beat_nxt  = last_beat ? '0 : beat + NBW'(1);
   assign pkt_nxt   = last_beat ? pkt + CNTW'(1) : pkt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat   <= '0;
         pkt    <= '0;
         nb_q   <= '0;
         npkt_q <= '0;
      end else if (load) begin
         beat   <= '0;
         pkt    <= '0;
         nb_q   <= nb;
         npkt_q <= npkt;
      end else if (en) begin
         beat <= beat_nxt;
         pkt  <= pkt_nxt;
      end
   end

endmodule

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet source: pkt_count packets of len_bytes bytes each,
// byte lane i of beat b in packet p carries (p + b*BYTES + i) mod 256.
//   ACLK, RST          : clock, asynchronous active-high reset
//   start              : run request, honoured only in IDLE
//   len_bytes          : packet length in bytes (latched on start)
//   pkt_count          : packets in the run (latched on start)
//   TREADY / TVALID .. : AXI4-Stream master channel, all outputs registered
//   busy               : packets are being sent
//   done               : one-cycle pulse after the final handshake
module axi4_stream_pkt_gen
   import axi4_stream_pkt_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 2,
   parameter int NUM_DEST   = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    ACLK,
   input  logic                    RST,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    len_bytes,
   input  logic [15:0]             pkt_count,
   input  logic                    TREADY,
   output logic                    TVALID,
   output logic [DATA_WIDTH-1:0]   TDATA,
   output logic [DATA_WIDTH/8-1:0] TKEEP,
   output logic [DATA_WIDTH/8-1:0] TSTRB,
   output logic                    TLAST,
   output logic [ID_WIDTH-1:0]     TID,
   output logic [DEST_WIDTH-1:0]   TDEST,
   output logic                    busy,
   output logic                    done
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int NBW   = LEN_WIDTH + 1;

   state_t                state_q, state_nxt;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [NBW-1:0]        nb_in, nb_q, beat_nxt;
   logic [15:0]           pkt_nxt;
   logic                  last_beat, last_pkt;
   logic                  accept, nonzero, hs, fin;

   // Payload of the beat to be presented after this edge.
   logic [15:0]           pl_p;
   logic [NBW-1:0]        pl_b, pl_nb;
   logic [LEN_WIDTH-1:0]  pl_len;
   logic [63:0]           km;
   logic [DATA_WIDTH-1:0] pl_data;
   logic [BYTES-1:0]      pl_keep;
   logic                  pl_last;

   assign nb_in   = NBW'(beats_per_pkt(32'(len_bytes), BYTES));
   assign nonzero = (len_bytes != '0) && (pkt_count != '0);
   assign accept  = (state_q == ST_IDLE) && start;
   assign hs      = TVALID && TREADY;
   assign fin     = hs && last_beat && last_pkt;
   assign TSTRB   = TKEEP;

   axi4_stream_pkt_ctr #(
      .NBW  (NBW),
      .CNTW (16)
   ) u_ctr (
      .clk       (ACLK),
      .rst       (RST),
      .load      (accept),
      .en        (hs),
      .nb        (nb_in),
      .npkt      (pkt_count),
      .nb_q      (nb_q),
      .last_beat (last_beat),
      .last_pkt  (last_pkt),
      .beat_nxt  (beat_nxt),
      .pkt_nxt   (pkt_nxt)
   );

   always_ff @(posedge ACLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (accept) len_q <= len_bytes;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: if (start) state_nxt = nonzero ? ST_SEND : ST_DONE;
         ST_SEND: if (fin) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // In IDLE the next beat is beat 0 of packet 0 of the new run, using the
   // live inputs; otherwise it is the successor of the beat on the bus.
   always_comb begin
      pl_p   = '0;
      pl_b   = '0;
      pl_nb  = nb_q;
      pl_len = len_q;
      if (state_q == ST_IDLE) begin
         pl_nb  = nb_in;
         pl_len = len_bytes;
      end else begin
         pl_p = pkt_nxt;
         pl_b = beat_nxt;
      end
      pl_last = (pl_b == pl_nb - NBW'(1));
      km      = last_keep(32'(pl_len), BYTES);
      pl_keep = pl_last ? km[BYTES-1:0] : '1;
      pl_data = '0;
      for (int i = 0; i < BYTES; i++)
         pl_data[8*i +: 8] = pattern_byte(32'(pl_p), 32'(pl_b), i, BYTES);
   end

   always_ff @(posedge ACLK or posedge RST) begin
      if (RST) begin
         TVALID <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         TDATA  <= '0;
         TKEEP  <= '0;
         TLAST  <= 1'b0;
         TID    <= '0;
         TDEST  <= '0;
      end else begin
         TVALID <= (state_nxt == ST_SEND);
         busy   <= (state_nxt == ST_SEND);
         done   <= (state_nxt == ST_DONE);
         if ((accept && nonzero) || (hs && !fin)) begin
            TDATA <= pl_data;
            TKEEP <= pl_keep;
            TLAST <= pl_last;
            TID   <= ID_WIDTH'(pl_p);
            TDEST <= DEST_WIDTH'(32'(pl_p) % NUM_DEST);
         end else if (fin) begin
            TDATA <= '0;
            TKEEP <= '0;
            TLAST <= 1'b0;
            TID   <= '0;
            TDEST <= '0;
         end
      end
   end

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
module tb_axi4_stream_pkt_gen;

   logic        ACLK = 1'b0;
   logic        RST  = 1'b1;
   logic        start = 1'b0;
   logic [15:0] len_bytes = '0;
   logic [15:0] pkt_count = '0;
   logic        TREADY = 1'b0;
   logic        TVALID, TLAST, busy, done;
   logic [31:0] TDATA;
   logic [3:0]  TKEEP, TSTRB;
   logic [7:0]  TID;
   logic [1:0]  TDEST;

   axi4_stream_pkt_gen #(
      .DATA_WIDTH (32),
      .ID_WIDTH   (8),
      .DEST_WIDTH (2),
      .NUM_DEST   (4),
      .LEN_WIDTH  (16)
   ) dut (
      .ACLK      (ACLK),
      .RST       (RST),
      .start     (start),
      .len_bytes (len_bytes),
      .pkt_count (pkt_count),
      .TREADY    (TREADY),
      .TVALID    (TVALID),
      .TDATA     (TDATA),
      .TKEEP     (TKEEP),
      .TSTRB     (TSTRB),
      .TLAST     (TLAST),
      .TID       (TID),
      .TDEST     (TDEST),
      .busy      (busy),
      .done      (done)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [7:0]  id;
      logic [1:0]  dest;
   } beat_t;

   beat_t q[$];
   int    tests = 0;
   int    fails = 0;
   int    exp_done = 0;
   int    done_seen = 0;
   int    hs_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: walk the packet byte stream in BYTES-sized chunks.
   task automatic push_model(input int len, input int cnt);
      beat_t e;
      for (int p = 0; p < cnt; p++) begin
         for (int off = 0; off < len; off += 4) begin
            for (int i = 0; i < 4; i++) begin
               e.data[8*i +: 8] = 8'((p + off + i) % 256);
               e.keep[i]        = (off + i) < len;
            end
            e.last = (off + 4) >= len;
            e.id   = 8'(p % 256);
            e.dest = 2'(p % 4);
            q.push_back(e);
         end
      end
   endtask

   // Monitor: scoreboard pop on handshake, stall stability, done checks.
   beat_t prev;
   logic  prev_stall = 1'b0;
   always @(negedge ACLK) begin
      if (RST) begin
         prev_stall = 1'b0;
      end else begin
         beat_t e;
         chk("busy_eq_tvalid", 64'(busy), 64'(TVALID));
         chk("tstrb_eq_tkeep", 64'(TSTRB), 64'(TKEEP));
         if (prev_stall) begin
            chk("stall_tvalid", 64'(TVALID), 64'd1);
            chk("stall_tdata", 64'(TDATA), 64'(prev.data));
            chk("stall_tkeep", 64'(TKEEP), 64'(prev.keep));
            chk("stall_tlast", 64'(TLAST), 64'(prev.last));
            chk("stall_tid", 64'(TID), 64'(prev.id));
         end
         if (TVALID && TREADY) begin
            hs_cnt++;
            if (q.size() == 0) begin
               chk("unexpected_beat", 64'(q.size()), 64'd1);
            end else begin
               e = q.pop_front();
               chk("tdata", 64'(TDATA), 64'(e.data));
               chk("tkeep", 64'(TKEEP), 64'(e.keep));
               chk("tlast", 64'(TLAST), 64'(e.last));
               chk("tid", 64'(TID), 64'(e.id));
               chk("tdest", 64'(TDEST), 64'(e.dest));
            end
         end
         if (done) begin
            done_seen++;
            chk("done_tvalid", 64'(TVALID), 64'd0);
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_queue_empty", 64'(q.size()), 64'd0);
         end
         prev_stall = TVALID && !TREADY;
         prev.data = TDATA; prev.keep = TKEEP; prev.last = TLAST;
         prev.id = TID; prev.dest = TDEST;
      end
   end

   // mode 0: TREADY=1, 1: random, 2: 1,0,0,1,0,1,1 then 1
   function automatic logic rdy(input int mode, input int c);
      logic [6:0] pat;
      pat = 7'b1101001;
      if (mode == 1) return 1'($urandom_range(0, 1));
      if (mode == 2 && c < 7) return pat[c];
      return 1'b1;
   endfunction

   // Entered just after a rising edge with the DUT in IDLE.
   task automatic run(input int len, input int cnt, input int mode);
      bit nz;
      nz = (len != 0) && (cnt != 0);
      push_model(len, cnt);
      exp_done++;
      start = 1'b1; len_bytes = 16'(len); pkt_count = 16'(cnt);
      TREADY = rdy(mode, 0);
      @(posedge ACLK); #1;
      start = 1'b0;
      chk("latency_tvalid", 64'(TVALID), 64'(nz));
      chk("latency_busy", 64'(busy), 64'(nz));
      for (int c = 1; c < 3000 && done_seen < exp_done; c++) begin
         TREADY = rdy(mode, c);
         @(posedge ACLK); #1;
      end
      chk("run_completed", 64'(done_seen), 64'(exp_done));
      done_seen = exp_done;
      q.delete();
   endtask

   int h0;

   initial begin
      #2;
      chk("rst_tvalid", 64'(TVALID), 64'd0);
      chk("rst_tdata", 64'(TDATA), 64'd0);
      chk("rst_busy_done", 64'({busy, done, TLAST, TKEEP, TID, TDEST}), 64'd0);
      @(posedge ACLK); #1; RST = 1'b0;
      @(posedge ACLK); #1;

      run(16, 1, 0);
      run(10, 3, 0);
      h0 = hs_cnt;
      run(8, 2, 2);
      chk("pattern_handshakes", 64'(hs_cnt - h0), 64'd4);
      run(4, 5, 0);
      h0 = hs_cnt;
      run(0, 3, 0);
      run(12, 0, 0);
      chk("zero_len_no_beats", 64'(hs_cnt - h0), 64'd0);
      run(7, 2, 1);
      run(1, 6, 1);

      // Reset in the middle of a packet: no done pulse, outputs clear at once.
      push_model(16, 2);
      start = 1'b1; len_bytes = 16'd16; pkt_count = 16'd2; TREADY = 1'b1;
      @(posedge ACLK); #1; start = 1'b0;
      @(posedge ACLK); #1;
      @(posedge ACLK); #2;
      RST = 1'b1;
      q.delete();
      #1;
      chk("midrst_tvalid", 64'(TVALID), 64'd0);
      chk("midrst_tdata", 64'(TDATA), 64'd0);
      chk("midrst_others", 64'({busy, done, TLAST, TKEEP, TSTRB, TID, TDEST}), 64'd0);
      @(posedge ACLK); #1; RST = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("midrst_no_done", 64'(done_seen), 64'(exp_done));
      run(8, 1, 0);

      for (int r = 0; r < 8; r++)
         run(int'($urandom_range(0, 40)), int'($urandom_range(0, 4)), 1);

      chk("done_total", 64'(done_seen), 64'(exp_done));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
